spi_regbank: RTL and testbench

Clock-domain consumer of the 40-bit SPI slave shift register. Synchronises the master's chip-select and serial clock into the system clock, checks that a complete 40-bit frame arrived, and decodes it into either a one-cycle register-write strobe or a status read. It then loads the response word that the SPI slave shifts out on the next frame. It sits between `spi_slave` (`q` → `spi_q`, `spi_d` → `d`) and the robot control/odometry logic.

---
 rtl/spi_regbank_if.sv | 22 ++
 rtl/spi_regbank.sv | 116 +++++++++++
 tb/tb_spi_regbank.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_regbank_if.sv
// SPI-side and write-side signals of spi_regbank, bundled for the port list.
// slave = the regbank itself, master = whatever drives the SPI frame and consumes writes.
interface spi_regbank_if;
  logic        spi_cs;
  logic        spi_sck;
  logic [39:0] spi_q;
  logic [39:0] spi_d;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        frame_err;

  modport slave (
    input  spi_cs, spi_sck, spi_q,
    output spi_d, wr_strobe, wr_addr, wr_data, frame_err
  );

  modport master (
    output spi_cs, spi_sck, spi_q,
    input  spi_d, wr_strobe, wr_addr, wr_data, frame_err
  );
endinterface

// File: rtl/spi_regbank.sv
// Decodes 40-bit SPI frames into register-write strobes and status-read responses.
// Optional SPI_REGBANK_ERRCNT_EN adds a saturating frame-error counter readable at 7'h7F.
module spi_regbank #(
  parameter int NREG = 16
) (
  input  logic              clk,
  input  logic              reset,
  spi_regbank_if.slave      bus,
  input  logic [NREG*32-1:0] status_in
);

  typedef enum logic [1:0] {IDLE, ACTIVE, CHECK, EXEC} state_t;

  state_t      state, state_n;
  logic [1:0]  cs_sync, sck_sync;
  logic        cs_prev, sck_prev;
  logic        cs_s, sck_s, cs_fall, cs_rise, sck_rise;
  logic [5:0]  bitcnt;
  logic [39:0] frame;
  logic [39:0] spi_d_r;
  logic [31:0] rdata;
  logic        pend_start;
  logic        frame_good;

  // Two-flop synchronisers plus a third flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync  <= '0;
      sck_sync <= '0;
      cs_prev  <= 1'b0;
      sck_prev <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[0], bus.spi_cs};
      sck_sync <= {sck_sync[0], bus.spi_sck};
      cs_prev  <= cs_sync[1];
      sck_prev <= sck_sync[1];
    end
  end

  assign cs_s     = cs_sync[1];
  assign sck_s    = sck_sync[1];
  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;
  assign sck_rise = ~sck_prev & sck_s;

  assign frame_good = (bitcnt == 6'd40);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (cs_fall) state_n = ACTIVE;
      ACTIVE: if (cs_rise) state_n = CHECK;
      CHECK:  state_n = frame_good ? EXEC : IDLE;
      // A new frame that started while we were finishing the last one is picked up here.
      EXEC:   state_n = (pend_start | cs_fall) ? ACTIVE : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt     <= '0;
      frame      <= '0;
      pend_start <= 1'b0;
    end else begin
      pend_start <= (state == CHECK) && cs_fall;
      if (state_n == ACTIVE && state != ACTIVE)
        bitcnt <= '0;
      else if (state == ACTIVE && sck_rise && bitcnt != 6'd63)
        bitcnt <= bitcnt + 6'd1;
      if (state == CHECK && frame_good)
        frame <= bus.spi_q;
    end
  end

  assign bus.wr_strobe = (state == EXEC) && frame[39];
  assign bus.wr_addr   = frame[38:32];
  assign bus.wr_data   = frame[31:0];
  assign bus.frame_err = (state == CHECK) && !frame_good;

`ifdef SPI_REGBANK_ERRCNT_EN
  logic [7:0] errcnt;
  always_ff @(posedge clk) begin
    if (reset)
      errcnt <= '0;
    else if (bus.frame_err && errcnt != 8'hFF)
      errcnt <= errcnt + 8'd1;
  end
`endif

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREG; i++)
      if (int'(frame[38:32]) == i) rdata = status_in[i*32 +: 32];
`ifdef SPI_REGBANK_ERRCNT_EN
    if (frame[38:32] == 7'h7F) rdata = {24'h0, errcnt};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset)
      spi_d_r <= '0;
    else if (state == EXEC)
      spi_d_r <= {1'b1, frame[38:32], rdata};
    else if (bus.frame_err)
      spi_d_r <= '0;
  end

  assign bus.spi_d = spi_d_r;

endmodule

// File: tb/tb_spi_regbank.sv
// Directed, table-driven bench for spi_regbank: frames driven at the pins, outputs
// observed for 8 clocks after chip-select rises.
module tb_spi_regbank;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic reset;
  logic [NREG*32-1:0] status_in;
  int total = 0;
  int bad = 0;

  spi_regbank_if bus();

  spi_regbank #(.NREG(NREG)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .status_in (status_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          npulse;
    logic [39:0] q;
    logic        exp_stb;
    logic [6:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [39:0] exp_d;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Watch 8 cycles after the cs rise; cycle k is sampled at the negedge after posedge k.
  task automatic observe(output int stb_n, output int stb_at, output logic [6:0] a,
                         output logic [31:0] dd, output int err_n, output int err_at,
                         output logic both, output logic [39:0] d5, output logic [39:0] d8);
    stb_n = 0; stb_at = 0; err_n = 0; err_at = 0; both = 1'b0;
    a = '0; dd = '0; d5 = '0; d8 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.wr_strobe) begin
        stb_n++; stb_at = k; a = bus.wr_addr; dd = bus.wr_data;
      end
      if (bus.frame_err) begin
        err_n++; err_at = k;
      end
      if (bus.wr_strobe && bus.frame_err) both = 1'b1;
      if (k == 5) d5 = bus.spi_d;
      if (k == 8) d8 = bus.spi_d;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int p = 0; p < n; p++) begin
      bus.spi_sck = 1'b1; repeat (4) @(negedge clk);
      bus.spi_sck = 1'b0; repeat (4) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int npulse, input logic [39:0] q,
                           output int stb_n, output int stb_at, output logic [6:0] a,
                           output logic [31:0] dd, output int err_n, output int err_at,
                           output logic both, output logic [39:0] d5, output logic [39:0] d8);
    bus.spi_q = q;
    @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    pulses(npulse);
    bus.spi_cs = 1'b1;
    observe(stb_n, stb_at, a, dd, err_n, err_at, both, d5, d8);
  endtask

  task automatic do_reset(input logic cs_level);
    reset = 1'b1;
    bus.spi_cs = cs_level;
    bus.spi_sck = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int stb_n, stb_at, err_n, err_at;
    logic [6:0] a;
    logic [31:0] dd;
    logic both;
    logic [39:0] d5, d8, exp7f;

    for (int i = 0; i < NREG; i++) status_in[i*32 +: 32] = 32'h1000_0000 + i;
    status_in[5*32 +: 32] = 32'hDEADBEEF;
    status_in[3*32 +: 32] = 32'h0BADF00D;
    bus.spi_q = '0;

    vecs[0] = '{40, 40'h05_0000_0000, 1'b0, 7'h00, 32'h0,        1'b0, 40'h85_DEADBEEF};
    vecs[1] = '{40, 40'h83_1234_5678, 1'b1, 7'h03, 32'h12345678, 1'b0, 40'h83_0BADF00D};
    vecs[2] = '{39, 40'h05_0000_0000, 1'b0, 7'h00, 32'h0,        1'b1, 40'h00_00000000};
    vecs[3] = '{40, 40'h20_0000_0000, 1'b0, 7'h00, 32'h0,        1'b0, 40'hA0_00000000};
    vecs[4] = '{40, 40'h8F_AAAA_5555, 1'b1, 7'h0F, 32'hAAAA5555, 1'b0, 40'h8F_1000000F};
    vecs[5] = '{40, 40'hD0_0000_0001, 1'b1, 7'h50, 32'h00000001, 1'b0, 40'hD0_00000000};
    vecs[6] = '{41, 40'h85_0000_0000, 1'b0, 7'h00, 32'h0,        1'b1, 40'h00_00000000};
    vecs[7] = '{0,  40'h85_0000_0000, 1'b0, 7'h00, 32'h0,        1'b1, 40'h00_00000000};

    do_reset(1'b1);
    chk("reset spi_d",     {24'h0, bus.spi_d}, 64'h0);
    chk("reset wr_strobe", {63'h0, bus.wr_strobe}, 64'h0);
    chk("reset wr_addr",   {57'h0, bus.wr_addr}, 64'h0);
    chk("reset wr_data",   {32'h0, bus.wr_data}, 64'h0);
    chk("reset frame_err", {63'h0, bus.frame_err}, 64'h0);

    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v].npulse, vecs[v].q, stb_n, stb_at, a, dd, err_n, err_at, both, d5, d8);
      chk($sformatf("v%0d strobe count", v), stb_n, {63'h0, vecs[v].exp_stb});
      chk($sformatf("v%0d err count", v), err_n, {63'h0, vecs[v].exp_err});
      chk($sformatf("v%0d strobe+err overlap", v), {63'h0, both}, 64'h0);
      chk($sformatf("v%0d spi_d at +5", v), {24'h0, d5}, {24'h0, vecs[v].exp_d});
      chk($sformatf("v%0d spi_d hold", v), {24'h0, d8}, {24'h0, vecs[v].exp_d});
      if (vecs[v].exp_stb) begin
        chk($sformatf("v%0d strobe cycle", v), stb_at, 64'd4);
        chk($sformatf("v%0d wr_addr", v), {57'h0, a}, {57'h0, vecs[v].exp_addr});
        chk($sformatf("v%0d wr_data", v), {32'h0, dd}, {32'h0, vecs[v].exp_data});
      end
      if (vecs[v].exp_err)
        chk($sformatf("v%0d err cycle", v), err_at, 64'd3);
    end

    // Error counter read-back after three over-long frames.
    do_reset(1'b1);
    chk("reset clears spi_d", {24'h0, bus.spi_d}, 64'h0);
    for (int r = 0; r < 3; r++)
      run_frame(41, 40'h05_0000_0000, stb_n, stb_at, a, dd, err_n, err_at, both, d5, d8);
    run_frame(40, 40'h7F_0000_0000, stb_n, stb_at, a, dd, err_n, err_at, both, d5, d8);
`ifdef SPI_REGBANK_ERRCNT_EN
    exp7f = 40'hFF_00000003;
`else
    exp7f = 40'hFF_00000000;
`endif
    chk("errcnt readback", {24'h0, d5}, {24'h0, exp7f});
    chk("errcnt read no strobe", stb_n, 64'd0);

    // Chip-select already low at reset release: the partial frame is ignored.
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    pulses(20);
    bus.spi_cs = 1'b1;
    observe(stb_n, stb_at, a, dd, err_n, err_at, both, d5, d8);
    chk("cs-low reset strobe", stb_n, 64'd0);
    chk("cs-low reset err", err_n, 64'd0);
    chk("cs-low reset spi_d", {24'h0, d5}, 64'h0);
    run_frame(40, 40'h83_1234_5678, stb_n, stb_at, a, dd, err_n, err_at, both, d5, d8);
    chk("after cs-low strobe", stb_n, 64'd1);
    chk("after cs-low wr_data", {32'h0, dd}, 64'h12345678);
    chk("after cs-low spi_d", {24'h0, d5}, 64'h83_0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
